// File: rtl/des_key_schedule.sv
// DES key-schedule generator: PC-1 on start, then one PC-2 round key per valid/ready handshake.
// Optional odd-parity key check is compiled in with `define DES_KEY_PARITY_CHECK_EN.
module des_key_schedule (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] key_in,
    input  logic        decrypt,
    output logic [47:0] round_key,
    output logic [3:0]  round_idx,
    output logic        key_valid,
    input  logic        key_ready,
    output logic        busy,
    output logic        done,
    output logic        parity_err
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_ERR = 2'd2} state_t;

    // Entries are DES bit numbers (1 = MSB of the source vector).
    localparam int PC1 [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                                10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                                63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                                14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2 [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                                23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                                41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    state_t      r_state, w_state_next;
    logic [27:0] r_c, r_d, w_c_next, w_d_next;
    logic [47:0] r_round_key;
    logic [3:0]  r_round_idx, w_idx_next, w_idx_inc;
    logic        r_decrypt, w_decrypt_next;
    logic        r_done, w_done_next;
    logic        r_parity_err, w_perr_next;
    logic        w_key_load, w_one_bit, w_parity_bad;
    logic [55:0] w_pc1, w_cd_next;
    logic [47:0] w_pc2;
    logic [7:0]  w_byte_par;

    function automatic logic [27:0] rot(input logic [27:0] x, input logic right, input logic one);
        case ({right, one})
            2'b00:   rot = {x[25:0], x[27:26]};
            2'b01:   rot = {x[26:0], x[27]};
            2'b10:   rot = {x[1:0], x[27:2]};
            default: rot = {x[0], x[27:1]};
        endcase
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 56; gi++) begin : g_pc1
            assign w_pc1[55-gi] = key_in[64-PC1[gi]];
        end
        for (gi = 0; gi < 48; gi++) begin : g_pc2
            assign w_pc2[47-gi] = w_cd_next[56-PC2[gi]];
        end
        for (gi = 0; gi < 8; gi++) begin : g_par
            assign w_byte_par[gi] = ^key_in[8*gi+7 -: 8];
        end
    endgenerate

`ifdef DES_KEY_PARITY_CHECK_EN
    assign w_parity_bad = ~&w_byte_par;
`else
    logic w_unused_par;
    assign w_unused_par = &w_byte_par;
    assign w_parity_bad = 1'b0;
`endif

    assign w_cd_next = {w_c_next, w_d_next};
    assign w_idx_inc = r_round_idx + 4'd1;
    assign w_one_bit = (w_idx_inc == 4'd1) || (w_idx_inc == 4'd8) || (w_idx_inc == 4'd15);

    always_comb begin
        w_state_next   = r_state;
        w_c_next       = r_c;
        w_d_next       = r_d;
        w_idx_next     = r_round_idx;
        w_decrypt_next = r_decrypt;
        w_perr_next    = r_parity_err;
        w_done_next    = 1'b0;
        w_key_load     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_decrypt_next = decrypt;
                    if (w_parity_bad) begin
                        w_perr_next  = 1'b1;
                        w_state_next = S_ERR;
                    end else begin
                        // Decrypt starts at K16, whose C16/D16 equal C0/D0.
                        w_c_next     = decrypt ? w_pc1[55:28] : rot(w_pc1[55:28], 1'b0, 1'b1);
                        w_d_next     = decrypt ? w_pc1[27:0]  : rot(w_pc1[27:0],  1'b0, 1'b1);
                        w_idx_next   = 4'd0;
                        w_key_load   = 1'b1;
                        w_state_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (key_ready) begin
                    if (r_round_idx == 4'd15) begin
                        w_done_next  = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_idx_next = w_idx_inc;
                        w_c_next   = rot(r_c, r_decrypt, w_one_bit);
                        w_d_next   = rot(r_d, r_decrypt, w_one_bit);
                        w_key_load = 1'b1;
                    end
                end
            end
            S_ERR:   w_state_next = S_ERR;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_c          <= '0;
            r_d          <= '0;
            r_round_key  <= '0;
            r_round_idx  <= '0;
            r_decrypt    <= 1'b0;
            r_done       <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_c          <= w_c_next;
            r_d          <= w_d_next;
            r_round_idx  <= w_idx_next;
            r_decrypt    <= w_decrypt_next;
            r_done       <= w_done_next;
            r_parity_err <= w_perr_next;
            if (w_key_load)
                r_round_key <= w_pc2;
        end
    end

    assign round_key  = r_round_key;
    assign round_idx  = r_round_idx;
    assign key_valid  = (r_state == S_RUN);
    assign busy       = (r_state == S_RUN);
    assign done       = r_done;
    assign parity_err = r_parity_err;
endmodule
